ssd_scan_ctrl: RTL

- Parametrised multiplexed seven-segment display driver. Generalises the fixed 4-digit scan in the top level to N digits.
- Adds a per-frame value snapshot (no tearing), inter-digit anti-ghost blanking, per-digit enables, decimal points and leading-zero suppression.
- Sits between game/score logic and the board anode/cathode pins.

---
 rtl/ssd_pkg.sv | 24 ++
 rtl/ssd_hex_decoder.sv | 11 +
 rtl/ssd_scan_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment scan controller: segment code table
// and width/polarity helpers.
package ssd_pkg;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
  };

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Idle level of an 8-bit output bus for the given drive polarity.
  function automatic logic [7:0] off_level(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/ssd_hex_decoder.sv
// Combinational nibble to active-high {a..g} segment code.
module ssd_hex_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] code_o
);

  assign code_o = SEG_CODES[nibble_i];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment driver with per-frame snapshot, anti-ghost
// blanking and leading-zero suppression. Optional PWM dimming: SSD_SCAN_DIMMING_EN.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int PRESCALE     = 262144,
  parameter int BLANK_CYCLES = 4,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         digit_en,
  input  logic                          lz_en,
`ifdef SSD_SCAN_DIMMING_EN
  input  logic [3:0]                    brightness,
`endif
  output logic [NUM_DIGITS-1:0]         an,
  output logic [7:0]                    seg,
  output logic [clog2(NUM_DIGITS)-1:0]  digit_idx
);

  localparam int PW = clog2(PRESCALE);
  localparam int IW = clog2(NUM_DIGITS);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0] BLANK_TH = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = (ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [7:0] SEG_OFF = off_level(ACTIVE_LOW != 0);

  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] snap_val_q, snap_val_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    prime_q, prime_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic                    tick_s, load_s, on_s, dp_s, zero_run_s;
  logic [3:0]              nib_s;
  logic [6:0]              code_s;
  logic [NUM_DIGITS-1:0]   lz_s;

`ifdef SSD_SCAN_DIMMING_EN
  logic [3:0] pwm_q;

  // Free-running duty-cycle counter compared against brightness.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q <= 4'd0;
    end else begin
      pwm_q <= pwm_q + 4'd1;
    end
  end
`endif

  // Prescaler, digit index and frame snapshot next-state.
  always_comb begin
    tick_s  = (pre_q == PRE_LAST);
    load_s  = prime_q || (tick_s && (idx_q == IDX_LAST));
    prime_d = 1'b0;
    if (tick_s) begin
      pre_d = '0;
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end else begin
      pre_d = pre_q + PW'(1);
      idx_d = idx_q;
    end
    if (load_s) begin
      snap_val_d = value;
      snap_dp_d  = dp_in;
    end else begin
      snap_val_d = snap_val_q;
      snap_dp_d  = snap_dp_q;
    end
  end

  // A digit is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    zero_run_s = 1'b1;
    lz_s       = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run_s = zero_run_s && (snap_val_q[4*i +: 4] == 4'h0);
      if (i > 0) begin
        lz_s[i] = lz_en && zero_run_s;
      end else begin
        lz_s[i] = 1'b0;
      end
    end
  end

  assign nib_s = snap_val_q[{idx_q, 2'b00} +: 4];
  assign dp_s  = snap_dp_q[idx_q];

  ssd_hex_decoder u_dec (
    .nibble_i (nib_s),
    .code_o   (code_s)
  );

  // Anode/segment values for the addressed digit, before polarity.
  always_comb begin
    on_s = (pre_q >= BLANK_TH) && digit_en[idx_q] && (!lz_s[idx_q] || dp_s);
`ifdef SSD_SCAN_DIMMING_EN
    on_s = on_s && (pwm_q <= brightness);
`endif
    an_d = '0;
    if (on_s) begin
      an_d[idx_q] = 1'b1;
    end else begin
      an_d = '0;
    end
    seg_d = {(lz_s[idx_q] ? 7'h00 : code_s), dp_s};
  end

  // State and output registers; XOR with the idle level applies polarity.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q      <= '0;
      idx_q      <= '0;
      snap_val_q <= '0;
      snap_dp_q  <= '0;
      prime_q    <= 1'b1;
      an_q       <= ANODE_OFF;
      seg_q      <= SEG_OFF;
    end else begin
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      snap_val_q <= snap_val_d;
      snap_dp_q  <= snap_dp_d;
      prime_q    <= prime_d;
      an_q       <= an_d ^ ANODE_OFF;
      seg_q      <= seg_d ^ SEG_OFF;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign digit_idx = idx_q;

endmodule
